// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift-register sequencing controller.
package shift_seq_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int NREQ_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        OUT     = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last winner.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(last) + k) % NREQ]) begin
                found                            = 1'b1;
                grant[(int'(last) + k) % NREQ]   = 1'b1;
                grant_idx                        = IDW'((int'(last) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Arbitrates parallel words, serializes them MSB first into an external SIPO
// shift register and returns the captured parallel word tagged with its owner.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              sr_din,
    output logic              sr_clr,
    input  logic [WIDTH-1:0]  sr_q,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [IDW-1:0]    out_id,
    input  logic              out_ready,
    output logic              busy
);

    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    seq_state_e       state, state_nxt;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] hold;
    logic [IDW-1:0]   id_r;
    logic [IDW-1:0]   last;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             accept;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req       (req_valid),
        .last      (last),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits for ready, ready is offered only in IDLE
    // (requests) and out_valid stays up with stable data until taken.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        sr_din    = 1'b0;
        sr_clr    = 1'b1;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) req_ready = grant;
                accept = |(req_valid & req_ready);
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                sr_clr = 1'b0;
                sr_din = hold[CNT_LAST - cnt];
                if (cnt == CNT_LAST) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                sr_clr    = 1'b0;
                state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            id_r      <= '0;
            last      <= IDW'(NREQ - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
                id_r <= grant_idx;
                last <= grant_idx;
                cnt  <= '0;
            end
            if (state == SHIFT) cnt <= cnt + 1'b1;
            // sr_q holds the complete word only during the CAPTURE cycle
            if (state == CAPTURE) begin
                out_data  <= sr_q;
                out_id    <= id_r;
                out_valid <= 1'b1;
            end
            if (state == OUT && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized bench for shift_seq_ctrl with a behavioural SIPO shift register
// and a transaction-timeline reference model.
module tb_shift_seq_ctrl;

    localparam int W    = 4;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ready;
    logic              sr_din, sr_clr;
    logic [W-1:0]      sr_q = '0;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [IDW-1:0]    out_id;
    logic              out_ready = 1'b1;
    logic              busy;

    shift_seq_ctrl #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .sr_din(sr_din), .sr_clr(sr_clr), .sr_q(sr_q),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready), .busy(busy)
    );

    // clock / environment shift register
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sr_clr) sr_q <= '0;
        else        sr_q <= {sr_q[W-2:0], sr_din};
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    logic [W-1:0]     wq [NREQ][$];
    logic [IDW+W-1:0] exp_q[$];
    int               served_ids[$];
    bit               m_idle = 1'b1;
    int               m_age  = 0;
    logic [W-1:0]     m_word = '0;
    int               m_id   = 0;
    int               m_last = NREQ - 1;
    bit               bp_mode = 1'b0;
    int               bp_cnt  = 0;
    bit               rand_ready = 1'b0;

    function automatic int rr_pick(input int last_i, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last_i + k) % NREQ]) return (last_i + k) % NREQ;
        end
        return -1;
    endfunction

    // driver + checks for one clock interval, then advance past the next edge
    task automatic tick();
        int               pick;
        logic [NREQ-1:0]  exp_rdy;
        bit               in_shift, in_cap, in_out;
        logic [IDW+W-1:0] front;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = (wq[i].size() > 0);
            req_data[i*W +: W]  = (wq[i].size() > 0) ? wq[i][0] : '0;
        end
        if (bp_mode && !m_idle && m_age > W && bp_cnt < 10) begin
            out_ready = 1'b0;
            bp_cnt++;
        end else if (rand_ready) begin
            out_ready = 1'($urandom_range(0, 1));
        end else begin
            out_ready = 1'b1;
        end
        #1;
        in_shift = !m_idle && m_age < W;
        in_cap   = !m_idle && m_age == W;
        in_out   = !m_idle && m_age > W;
        exp_rdy  = '0;
        pick     = -1;
        if (m_idle) begin
            pick = rr_pick(m_last, req_valid);
            if (pick >= 0) exp_rdy[pick] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("sr_clr", 32'(sr_clr), 32'(!(in_shift || in_cap)));
        chk("sr_din", 32'(sr_din), in_shift ? 32'(m_word[W-1-m_age]) : 32'd0);
        if (in_cap) chk("sr_q", 32'(sr_q), 32'(m_word));
        chk("out_valid", 32'(out_valid), 32'(in_out));
        if (in_out) begin
            front = (exp_q.size() > 0) ? exp_q[0] : '1;
            chk("out_data", 32'(out_data), 32'(front[W-1:0]));
            chk("out_id", 32'(out_id), 32'(front[IDW+W-1:W]));
        end
        if (m_idle) begin
            if (pick >= 0) begin
                m_idle = 1'b0;
                m_age  = 0;
                m_word = wq[pick][0];
                m_id   = pick;
                m_last = pick;
                bp_cnt = 0;
                exp_q.push_back({IDW'(pick), wq[pick][0]});
                void'(wq[pick].pop_front());
            end
        end else if (in_out) begin
            if (out_ready) begin
                m_idle = 1'b1;
                void'(exp_q.pop_front());
                served_ids.push_back(m_id);
            end
        end else begin
            m_age++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int pending();
        int n = m_idle ? 0 : 1;
        for (int i = 0; i < NREQ; i++) n += wq[i].size();
        return n;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (pending() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(pending()), 32'd0);
    endtask

    int s;

    initial begin
        // reset with requests present: nothing may be offered
        rst = 1'b1;
        req_valid = 2'b11;
        req_data  = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sr_clr", 32'(sr_clr), 32'd1);
        chk("rst_sr_din", 32'(sr_din), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick();

        // single word
        wq[0].push_back(4'hB);
        drain(40);

        // fairness with both requesters continuously valid
        s = served_ids.size();
        repeat (2) begin
            wq[0].push_back(4'h5);
            wq[1].push_back(4'hA);
        end
        drain(80);
        for (int k = s + 1; k < served_ids.size(); k++)
            chk("fair_alternate", 32'(served_ids[k] != served_ids[k-1]), 32'd1);

        // backpressure
        bp_mode = 1'b1;
        wq[0].push_back(4'h7);
        wq[1].push_back(4'h9);
        drain(80);
        bp_mode = 1'b0;

        // reset in the middle of shifting 4'h6
        wq[0].push_back(4'h6);
        for (int n = 0; n < 20 && !(!m_idle && m_age == 2); n++) tick();
        chk("mid_shift_reached", 32'(!m_idle && m_age == 2), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_sr_clr", 32'(sr_clr), 32'd1);
        chk("mrst_sr_din", 32'(sr_din), 32'd0);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_req_ready", 32'(req_ready), 32'd0);
        m_idle = 1'b1;
        m_age  = 0;
        m_last = NREQ - 1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s = served_ids.size();
        wq[0].push_back(4'h3);
        wq[1].push_back(4'hC);
        drain(60);
        chk("post_rst_count", 32'(served_ids.size() - s), 32'd2);
        if (served_ids.size() > s) chk("post_rst_first", 32'(served_ids[s]), 32'd0);

        // extremes from requester 1
        wq[1].push_back(4'h0);
        wq[1].push_back(4'hF);
        drain(60);

        // randomized traffic with random consumer stalls
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                wq[$urandom_range(0, NREQ-1)].push_back(W'($urandom_range(0, 15)));
            tick();
        end
        drain(2000);
        rand_ready = 1'b0;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
